// File: rtl/lenet_pkg.sv
// Shared constants and FSM state type for the LeNet image loader front end.
// Optional checksum output in img_loader is enabled by IMG_LOADER_CHKSUM_EN.
package lenet_pkg;

    localparam int SRAM_BANKS = 9;
    localparam int SRAM_DW    = 32;
    localparam int SRAM_AW    = 10;
    localparam int SRAM_LANES = 4;
    localparam int BANK_IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_e;

endpackage

// File: rtl/img_bank_map.sv
// Maps a raster pixel position (row, col) onto SRAM bank, word address
// and byte lane for the 3x3 interleaved bank layout.
module img_bank_map
    import lenet_pkg::*;
#(
    parameter int IMG_SIZE               = 32,
    parameter int DATA_NUM_PER_SRAM_ADDR = 4,
    localparam int CW = $clog2(IMG_SIZE),
    localparam int LW = $clog2(DATA_NUM_PER_SRAM_ADDR)
) (
    input  logic [CW-1:0]         row,
    input  logic [CW-1:0]         col,
    output logic [BANK_IDX_W-1:0] bank,
    output logic [SRAM_AW-1:0]    addr,
    output logic [LW-1:0]         lane
);

    logic [31:0] r_w;
    logic [31:0] c_w;
    logic [31:0] wc_w;
    logic [31:0] dps_w;

    assign dps_w = 32'(DATA_NUM_PER_SRAM_ADDR);
    assign r_w   = 32'(row);
    assign c_w   = 32'(col);
    assign wc_w  = c_w / dps_w;

    // Adjacent rows and word-columns land in different banks so a 3x3
    // window can be fetched in one cycle.
    assign bank = BANK_IDX_W'((r_w % 32'd3) * 32'd3 + (wc_w % 32'd3));
    assign addr = SRAM_AW'((r_w / 32'd3) * 32'd3 + (wc_w / 32'd3));
    assign lane = LW'(c_w % dps_w);

endmodule

// File: rtl/img_loader.sv
// Streams one square image into nine interleaved SRAM banks.
// Define IMG_LOADER_CHKSUM_EN to add the 16-bit pixel checksum output.
module img_loader
    import lenet_pkg::*;
#(
    parameter int DATA_WIDTH             = 8,
    parameter int IMG_SIZE               = 32,
    parameter int DATA_NUM_PER_SRAM_ADDR = 4
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  load_start,
    input  logic                  pix_valid,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_ready,
    output logic                  sram_write_enable_a0,
    output logic                  sram_write_enable_a1,
    output logic                  sram_write_enable_a2,
    output logic                  sram_write_enable_a3,
    output logic                  sram_write_enable_a4,
    output logic                  sram_write_enable_a5,
    output logic                  sram_write_enable_a6,
    output logic                  sram_write_enable_a7,
    output logic                  sram_write_enable_a8,
    output logic [SRAM_LANES-1:0] sram_bytemask_a,
    output logic [SRAM_AW-1:0]    sram_waddr_a,
    output logic [SRAM_DW-1:0]    sram_wdata_a,
    output logic                  load_done
`ifdef IMG_LOADER_CHKSUM_EN
    ,
    output logic [15:0]           chksum
`endif
);

    localparam int CW = $clog2(IMG_SIZE);
    localparam int LW = $clog2(DATA_NUM_PER_SRAM_ADDR);
    localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 1);

    load_state_e state_q, state_d;
    logic [CW-1:0]         r_q, r_d;
    logic [CW-1:0]         c_q, c_d;
    logic [SRAM_BANKS-1:0] we_n_q, we_n_d;
    logic [SRAM_LANES-1:0] mask_q, mask_d;
    logic [SRAM_AW-1:0]    waddr_q, waddr_d;
    logic [SRAM_DW-1:0]    wdata_q, wdata_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic                  last_pix;
    logic [BANK_IDX_W-1:0] map_bank;
    logic [SRAM_AW-1:0]    map_addr;
    logic [LW-1:0]         map_lane;

    img_bank_map #(
        .IMG_SIZE               (IMG_SIZE),
        .DATA_NUM_PER_SRAM_ADDR (DATA_NUM_PER_SRAM_ADDR)
    ) u_map (
        .row  (r_q),
        .col  (c_q),
        .bank (map_bank),
        .addr (map_addr),
        .lane (map_lane)
    );

    assign pix_ready = (state_q == ST_LOAD);
    assign accept    = pix_valid && pix_ready;
    assign last_pix  = (r_q == LAST) && (c_q == LAST);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        unique case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    r_d     = '0;
                    c_d     = '0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (last_pix) begin
                        state_d = ST_DONE;
                        r_d     = '0;
                        c_d     = '0;
                    end else if (c_q == LAST) begin
                        c_d = '0;
                        r_d = r_q + CW'(1);
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        we_n_d  = '1;
        mask_d  = '0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = (state_q == ST_DONE);
        if (accept) begin
            we_n_d  = ~(SRAM_BANKS'(1) << map_bank);
            mask_d  = SRAM_LANES'(1) << map_lane;
            waddr_d = map_addr;
            wdata_d = SRAM_DW'({DATA_NUM_PER_SRAM_ADDR{pix_data}});
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            we_n_q  <= '1;
            mask_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            we_n_q  <= we_n_d;
            mask_q  <= mask_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

`ifdef IMG_LOADER_CHKSUM_EN
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (state_q == ST_IDLE && load_start) begin
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_q + 16'(pix_data);
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign chksum = sum_q;
`endif

    assign sram_write_enable_a0 = we_n_q[0];
    assign sram_write_enable_a1 = we_n_q[1];
    assign sram_write_enable_a2 = we_n_q[2];
    assign sram_write_enable_a3 = we_n_q[3];
    assign sram_write_enable_a4 = we_n_q[4];
    assign sram_write_enable_a5 = we_n_q[5];
    assign sram_write_enable_a6 = we_n_q[6];
    assign sram_write_enable_a7 = we_n_q[7];
    assign sram_write_enable_a8 = we_n_q[8];
    assign sram_bytemask_a      = mask_q;
    assign sram_waddr_a         = waddr_q;
    assign sram_wdata_a         = wdata_q;
    assign load_done            = done_q;

endmodule

// File: tb/tb_img_loader.sv
// Self-checking bench for img_loader: scoreboard on every SRAM write
// plus a table of hand-computed bank/address/lane vectors.
module tb_img_loader;

    localparam int N    = 32;
    localparam int NPIX = N * N;

    logic        clk = 1'b0;
    logic        srstn = 1'b1;
    logic        load_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = 8'h00;
    logic        pix_ready;
    logic        we0, we1, we2, we3, we4, we5, we6, we7, we8;
    logic [3:0]  mask;
    logic [9:0]  waddr;
    logic [31:0] wdata;
    logic        load_done;
`ifdef IMG_LOADER_CHKSUM_EN
    logic [15:0] chksum;
    logic [15:0] chk_done = 16'h0;
`endif

    always #5 clk = ~clk;

    img_loader dut (
        .clk                  (clk),
        .srstn                (srstn),
        .load_start           (load_start),
        .pix_valid            (pix_valid),
        .pix_data             (pix_data),
        .pix_ready            (pix_ready),
        .sram_write_enable_a0 (we0),
        .sram_write_enable_a1 (we1),
        .sram_write_enable_a2 (we2),
        .sram_write_enable_a3 (we3),
        .sram_write_enable_a4 (we4),
        .sram_write_enable_a5 (we5),
        .sram_write_enable_a6 (we6),
        .sram_write_enable_a7 (we7),
        .sram_write_enable_a8 (we8),
        .sram_bytemask_a      (mask),
        .sram_waddr_a         (waddr),
        .sram_wdata_a         (wdata),
        .load_done            (load_done)
`ifdef IMG_LOADER_CHKSUM_EN
        ,
        .chksum               (chksum)
`endif
    );

    typedef struct {
        logic [8:0]  we_n;
        logic [3:0]  mask;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic        last;
        int          idx;
    } exp_t;

    typedef struct {
        int r;
        int c;
        int bank;
        int addr;
        int mask;
    } vec_t;

    exp_t q[$];
    vec_t tbl[9];

    int compared = 0;
    int mismatched = 0;
    int nwr = 0;
    int ndone = 0;
    int m_r = 0;
    int m_c = 0;
    logic [15:0] m_sum = 16'h0;
    logic prev_fin = 1'b0;

    int          cap_bank [NPIX];
    logic [9:0]  cap_addr [NPIX];
    logic [3:0]  cap_mask [NPIX];
    logic [31:0] cap_data [NPIX];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d);
        exp_t e;
        int wc;
        int bank;
        wc      = m_c / 4;
        bank    = (m_r % 3) * 3 + (wc % 3);
        e.we_n  = ~(9'(1) << bank);
        e.mask  = 4'(1) << (m_c % 4);
        e.addr  = 10'((m_r / 3) * 3 + wc / 3);
        e.wdata = {d, d, d, d};
        e.last  = (m_r == N - 1) && (m_c == N - 1);
        e.idx   = m_r * N + m_c;
        m_sum   = m_sum + 16'(d);
        q.push_back(e);
        if (m_c == N - 1) begin
            m_c = 0;
            m_r = (m_r == N - 1) ? 0 : m_r + 1;
        end else begin
            m_c++;
        end
    endtask

    always @(negedge clk) begin
        logic [8:0] we;
        exp_t e;
        logic fin;
        int b;
        int nz;
        we  = {we8, we7, we6, we5, we4, we3, we2, we1, we0};
        fin = 1'b0;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("write_px%0d", e.idx),
                {9'h0, we, mask, waddr, wdata},
                {9'h0, e.we_n, e.mask, e.addr, e.wdata});
            b  = 15;
            nz = 0;
            for (int i = 0; i < 9; i++) begin
                if (!we[i]) begin
                    b = i;
                    nz++;
                end
            end
            cap_bank[e.idx] = (nz == 1) ? b : 15;
            cap_addr[e.idx] = waddr;
            cap_mask[e.idx] = mask;
            cap_data[e.idx] = wdata;
            nwr++;
            fin = e.last;
        end else begin
            chk("idle_outputs", {51'h0, we, mask}, {51'h0, 9'h1FF, 4'h0});
        end
        chk("load_done", {63'h0, load_done}, {63'h0, prev_fin});
        if (load_done) begin
            ndone++;
`ifdef IMG_LOADER_CHKSUM_EN
            chk("chksum_model", {48'h0, chksum}, {48'h0, m_sum});
            chk_done = chksum;
`endif
        end
        prev_fin = fin;
    end

    task automatic check_reset(input string name);
        chk({name, "_we"}, {55'h0, we8, we7, we6, we5, we4, we3, we2, we1, we0},
            {55'h0, 9'h1FF});
        chk({name, "_mask"}, {60'h0, mask}, 64'h0);
        chk({name, "_waddr"}, {54'h0, waddr}, 64'h0);
        chk({name, "_wdata"}, {32'h0, wdata}, 64'h0);
        chk({name, "_done"}, {63'h0, load_done}, 64'h0);
        chk({name, "_ready"}, {63'h0, pix_ready}, 64'h0);
`ifdef IMG_LOADER_CHKSUM_EN
        chk({name, "_chksum"}, {48'h0, chksum}, 64'h0);
`endif
    endtask

    task automatic do_load_start();
        @(negedge clk);
        pix_valid  = 1'b0;
        load_start = 1'b1;
        m_r = 0;
        m_c = 0;
        m_sum = 16'h0;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic stream(input int n, input int mode);
        int sent = 0;
        int guard = 0;
        bit pulsed = 0;
        while (sent < n && guard < 20000) begin
            @(negedge clk);
            guard++;
            load_start = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                pix_valid = 1'b0;
            end else begin
                pix_valid = 1'b1;
                unique case (mode)
                    0: pix_data = (sent == 0) ? 8'hA5 : 8'($urandom);
                    1: pix_data = 8'hFF;
                    3: pix_data = 8'h3C;
                    default: pix_data = 8'($urandom);
                endcase
            end
            if (mode == 0 && sent == 300 && !pulsed) begin
                load_start = 1'b1;
                pulsed = 1;
            end
            #1;
            if (pix_valid && pix_ready) begin
                push_exp(pix_data);
                sent++;
            end
        end
        if (sent < n) chk("stream_timeout", 64'(sent), 64'(n));
    endtask

    task automatic post_image(input int w0, input int d0);
        repeat (4) begin
            @(negedge clk);
            pix_valid = 1'b1;
            #1;
            chk("ready_after_done", {63'h0, pix_ready}, 64'h0);
        end
        pix_valid = 1'b0;
        @(negedge clk);
        chk("write_count", 64'(nwr - w0), 64'(NPIX));
        chk("done_pulses", 64'(ndone - d0), 64'h1);
    endtask

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int d0;
        tbl[0] = '{0, 0, 0, 0, 1};
        tbl[1] = '{4, 13, 3, 4, 2};
        tbl[2] = '{31, 31, 4, 32, 8};
        tbl[3] = '{1, 4, 4, 0, 1};
        tbl[4] = '{5, 27, 6, 5, 8};
        tbl[5] = '{2, 8, 8, 0, 1};
        tbl[6] = '{3, 31, 1, 5, 8};
        tbl[7] = '{30, 0, 0, 30, 1};
        tbl[8] = '{8, 20, 8, 7, 1};

        #1 srstn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        srstn = 1'b1;

        pix_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("ready_before_start", {63'h0, pix_ready}, 64'h0);
        end
        pix_valid = 1'b0;

        w0 = nwr;
        d0 = ndone;
        do_load_start();
        stream(NPIX, 0);
        post_image(w0, d0);
        for (int i = 0; i < 9; i++) begin
            int k;
            k = tbl[i].r * N + tbl[i].c;
            chk($sformatf("tbl_bank_%0d_%0d", tbl[i].r, tbl[i].c),
                64'(cap_bank[k]), 64'(tbl[i].bank));
            chk($sformatf("tbl_addr_%0d_%0d", tbl[i].r, tbl[i].c),
                {54'h0, cap_addr[k]}, 64'(tbl[i].addr));
            chk($sformatf("tbl_mask_%0d_%0d", tbl[i].r, tbl[i].c),
                {60'h0, cap_mask[k]}, 64'(tbl[i].mask));
        end
        chk("tbl_wdata_0_0", {32'h0, cap_data[0]}, 64'hA5A5A5A5);

        w0 = nwr;
        d0 = ndone;
        do_load_start();
        stream(NPIX, 1);
        post_image(w0, d0);
`ifdef IMG_LOADER_CHKSUM_EN
        chk("chksum_ff", {48'h0, chk_done}, 64'hFC00);
`endif

        do_load_start();
        stream(500, 2);
        @(negedge clk);
        pix_valid = 1'b0;
        #2 srstn = 1'b0;
        #1 check_reset("mid_reset");
        q.delete();
        m_r = 0;
        m_c = 0;
        repeat (2) @(negedge clk);
        srstn = 1'b1;
        pix_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("ready_after_reset", {63'h0, pix_ready}, 64'h0);
        end
        pix_valid = 1'b0;

        cap_bank[0] = 15;
        cap_addr[0] = 10'h3FF;
        cap_data[0] = 32'h0;
        do_load_start();
        stream(1, 3);
        @(negedge clk);
        pix_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("fresh_bank", 64'(cap_bank[0]), 64'h0);
        chk("fresh_addr", {54'h0, cap_addr[0]}, 64'h0);
        chk("fresh_wdata", {32'h0, cap_data[0]}, 64'h3C3C3C3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
